// File: rtl/can_bit_timing_if.sv
// can_bit_timing_if: MAC-side configuration and bit-stream signals of the CAN bit timing unit
interface can_bit_timing_if #(
    parameter int BRP_W   = 8,
    parameter int TSEG1_W = 8,
    parameter int TSEG2_W = 7,
    parameter int SJW_W   = 7
);
    logic               en;
    logic               fd_mode;
    logic [BRP_W-1:0]   nbrp;
    logic [BRP_W-1:0]   dbrp;
    logic [TSEG1_W-1:0] ntseg1;
    logic [TSEG1_W-1:0] dtseg1;
    logic [TSEG2_W-1:0] ntseg2;
    logic [TSEG2_W-1:0] dtseg2;
    logic [SJW_W-1:0]   nsjw;
    logic [SJW_W-1:0]   dsjw;
    logic               hard_sync_en;
    logic               rx;
    logic               tx_bit;
    logic               tx;
    logic               tx_req;
    logic               sample_pulse;
    logic               rx_bit;
    logic               bit_err;
    logic [1:0]         seg;

    modport master (
        output en, fd_mode, nbrp, dbrp, ntseg1, dtseg1, ntseg2, dtseg2, nsjw, dsjw,
               hard_sync_en, rx, tx_bit,
        input  tx, tx_req, sample_pulse, rx_bit, bit_err, seg
    );

    modport slave (
        input  en, fd_mode, nbrp, dbrp, ntseg1, dtseg1, ntseg2, dtseg2, nsjw, dsjw,
               hard_sync_en, rx, tx_bit,
        output tx, tx_req, sample_pulse, rx_bit, bit_err, seg
    );
endinterface

// File: rtl/can_bit_timing.sv
// can_bit_timing: single-clock CAN / CAN-FD bit timing with hard sync and SJW-limited resync
module can_bit_timing #(
    parameter int BRP_W   = 8,
    parameter int TSEG1_W = 8,
    parameter int TSEG2_W = 7,
    parameter int SJW_W   = 7
) (
    input logic             clk,
    input logic             rst,
    can_bit_timing_if.slave bus
);
    localparam int W = TSEG1_W + 2;

    typedef enum logic [1:0] {SYNC = 2'd0, TSEG1 = 2'd1, TSEG2 = 2'd2} seg_t;

    seg_t               seg;
    logic [BRP_W-1:0]   pcnt, brp;
    logic [TSEG1_W:0]   tcnt;
    logic [TSEG1_W-1:0] tseg1;
    logic [TSEG2_W-1:0] tseg2;
    logic [SJW_W-1:0]   sjw, ext, shr, ext_n, shr_n;
    logic [W-1:0]       k1, rem;
    logic               fd_sel, lock, rx_prev, tx, rx_bit, sample_pulse, bit_err;
    logic               tick, fall, resync, trunc, hsync, last1, last2;

    assign brp   = fd_sel ? bus.dbrp   : bus.nbrp;
    assign tseg1 = fd_sel ? bus.dtseg1 : bus.ntseg1;
    assign tseg2 = fd_sel ? bus.dtseg2 : bus.ntseg2;
    assign sjw   = fd_sel ? bus.dsjw   : bus.nsjw;

    // >= keeps the prescaler from running away if brp ever shrinks under it
    assign tick   = pcnt >= brp;
    assign fall   = rx_prev && !bus.rx;
    assign resync = fall && !bus.hard_sync_en && !lock && tx;
    assign k1     = W'(tcnt) + W'(1);
    assign rem    = W'(tseg2) - W'(tcnt);
    assign trunc  = resync && seg == TSEG2 && rem <= W'(sjw);
    assign hsync  = (fall && bus.hard_sync_en) || trunc;
    assign ext_n  = resync && seg == TSEG1 ? (k1 < W'(sjw) ? SJW_W'(k1) : sjw) : ext;
    assign shr_n  = resync && seg == TSEG2 ? sjw : shr;
    assign last1  = k1 >= W'(tseg1) + W'(ext_n);
    assign last2  = k1 + W'(shr_n) >= W'(tseg2);

    assign bus.tx_req       = bus.en && !rst && seg == TSEG2 && tick && last2 && !hsync;
    assign bus.tx           = tx;
    assign bus.rx_bit       = rx_bit;
    assign bus.sample_pulse = sample_pulse;
    assign bus.bit_err      = bit_err;
    assign bus.seg          = seg;

    // Only a sync (hard or TSEG2 truncation) realigns the prescaler; resync just moves segment ends
    always_ff @(posedge clk) begin
        if (rst || !bus.en) begin
            pcnt         <= '0;
            tcnt         <= '0;
            seg          <= SYNC;
            tx           <= 1'b1;
            rx_bit       <= 1'b1;
            sample_pulse <= 1'b0;
            bit_err      <= 1'b0;
            rx_prev      <= 1'b1;
            lock         <= 1'b0;
            ext          <= '0;
            shr          <= '0;
            fd_sel       <= rst ? 1'b0 : bus.fd_mode;
        end else begin
            rx_prev      <= bus.rx;
            sample_pulse <= 1'b0;
            bit_err      <= 1'b0;
            if (hsync) begin
                seg  <= TSEG1;
                tcnt <= '0;
                pcnt <= '0;
                lock <= 1'b0;
                ext  <= '0;
                shr  <= '0;
            end else begin
                pcnt <= tick ? '0 : pcnt + 1'b1;
                lock <= lock || resync;
                ext  <= ext_n;
                shr  <= shr_n;
                if (tick) begin
                    if (seg == SYNC) begin
                        seg  <= TSEG1;
                        tcnt <= '0;
                    end else if (seg == TSEG1 && last1) begin
                        seg          <= TSEG2;
                        tcnt         <= '0;
                        ext          <= '0;
                        lock         <= 1'b0;
                        sample_pulse <= 1'b1;
                        rx_bit       <= bus.rx;
                        bit_err      <= tx != bus.rx;
                        fd_sel       <= bus.fd_mode;
                    end else if (seg != TSEG1 && last2) begin
                        seg  <= SYNC;
                        tcnt <= '0;
                        shr  <= '0;
                        tx   <= bus.tx_bit;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_can_bit_timing.sv
// tb_can_bit_timing: directed timing scenarios plus randomized traffic against a tq-index bit model
module tb_can_bit_timing;
    localparam int BRP_W = 8, TSEG1_W = 8, TSEG2_W = 7, SJW_W = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_txreq = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.tx_req) n_txreq <= n_txreq + 1;

    can_bit_timing_if #(.BRP_W(BRP_W), .TSEG1_W(TSEG1_W), .TSEG2_W(TSEG2_W), .SJW_W(SJW_W)) bus ();

    can_bit_timing #(.BRP_W(BRP_W), .TSEG1_W(TSEG1_W), .TSEG2_W(TSEG2_W), .SJW_W(SJW_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Model: position in a bit is the tq index q (0 = SYNC) plus clock phase ph inside the tq
    int m_q = 0, m_ph = 0, m_sq = 0, m_ext = 0, m_shr = 0;
    bit m_past = 0, m_lock = 0, m_fd = 0, m_tx = 1, m_rxb = 1, m_sp = 0, m_be = 0, m_rxp = 1;
    int e_seg, e_ext, e_shr;
    bit e_tick, e_rs, e_sync, e_samp, e_end;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void eval();
        int brp, t1, t2, sjw;
        bit fall;
        brp = m_fd ? int'(bus.dbrp) : int'(bus.nbrp);
        t1 = m_fd ? int'(bus.dtseg1) : int'(bus.ntseg1);
        t2 = m_fd ? int'(bus.dtseg2) : int'(bus.ntseg2);
        sjw = m_fd ? int'(bus.dsjw) : int'(bus.nsjw);
        e_seg = m_q == 0 ? 0 : (m_past ? 2 : 1);
        e_tick = m_ph == brp;
        fall = m_rxp && !bus.rx;
        e_rs = fall && !bus.hard_sync_en && !m_lock && m_tx;
        e_sync = (fall && bus.hard_sync_en) || (e_rs && e_seg == 2 && t2 - (m_q - m_sq - 1) <= sjw);
        e_ext = (e_rs && e_seg == 1) ? (m_q < sjw ? m_q : sjw) : m_ext;
        e_shr = (e_rs && e_seg == 2) ? sjw : m_shr;
        e_samp = !e_sync && e_tick && e_seg == 1 && m_q >= t1 + e_ext;
        e_end = !e_sync && e_tick && e_seg == 2 && m_q - m_sq >= t2 - e_shr;
    endfunction

    task automatic model_step();
        eval();
        if (rst || !bus.en) begin
            m_q = 0; m_ph = 0; m_past = 0; m_ext = 0; m_shr = 0; m_lock = 0;
            m_tx = 1; m_rxb = 1; m_sp = 0; m_be = 0; m_rxp = 1;
            m_fd = rst ? 1'b0 : bus.fd_mode;
        end else begin
            m_sp = 0;
            m_be = 0;
            if (e_sync) begin
                m_q = 1; m_ph = 0; m_past = 0; m_lock = 0; m_ext = 0; m_shr = 0;
            end else begin
                m_lock = m_lock || e_rs;
                m_ext = e_ext;
                m_shr = e_shr;
                if (!e_tick) m_ph++;
                else begin
                    m_ph = 0;
                    if (e_samp) begin
                        m_past = 1; m_sq = m_q; m_q++; m_sp = 1; m_rxb = bus.rx;
                        m_be = m_tx != bus.rx; m_fd = bus.fd_mode; m_lock = 0;
                    end else if (e_end) begin
                        m_q = 0; m_past = 0; m_ext = 0; m_shr = 0; m_tx = bus.tx_bit;
                    end else m_q++;
                end
            end
            m_rxp = bus.rx;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            eval();
            chk("seg", int'(bus.seg), e_seg);
            chk("tx", int'(bus.tx), int'(m_tx));
            chk("rx_bit", int'(bus.rx_bit), int'(m_rxb));
            chk("sample_pulse", int'(bus.sample_pulse), int'(m_sp));
            chk("bit_err", int'(bus.bit_err), int'(m_be));
            chk("tx_req", int'(bus.tx_req), int'(bus.en && !rst && e_end));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_sp(output int c);
        c = -1;
        for (int i = 0; i < 400; i++) begin
            step();
            if (bus.sample_pulse) begin
                c = cyc;
                return;
            end
        end
        n_chk++; n_fail++;
        $display("FAIL sample_wait: no sample_pulse in 400 cycles, required one");
    endtask

    task automatic wait_txreq(output int c);
        c = -1;
        for (int i = 0; i < 400; i++) begin
            step();
            if (bus.tx_req) begin
                c = cyc;
                return;
            end
        end
        n_chk++; n_fail++;
        $display("FAIL txreq_wait: no tx_req in 400 cycles, required one");
    endtask

    initial begin
        int a, b, c, d, n, s;
        bus.en = 0; bus.fd_mode = 0; bus.hard_sync_en = 0; bus.rx = 1; bus.tx_bit = 1;
        bus.nbrp = 8'd3; bus.ntseg1 = 8'd5; bus.ntseg2 = 7'd2; bus.nsjw = 7'd1;
        bus.dbrp = 8'd0; bus.dtseg1 = 8'd3; bus.dtseg2 = 7'd1; bus.dsjw = 7'd1;
        repeat (3) step();
        rst = 0;
        chk("reset_seg", int'(bus.seg), 0);
        chk("reset_tx", int'(bus.tx), 1);
        chk("reset_rx_bit", int'(bus.rx_bit), 1);
        bus.en = 1;

        // 32-clk nominal bit, one tx_req per bit, sample 24 clk after launch
        wait_sp(a);
        s = n_txreq;
        wait_sp(b);
        chk("t1_bit_period", b - a, 32);
        chk("t1_txreq_per_bit", n_txreq - s, 1);
        wait_txreq(c);
        wait_sp(d);
        chk("t1_launch_to_sample", d - (c + 1), 24);

        // hard sync mid-TSEG2: next cycle TSEG1, sample after tseg1 full tq
        wait_sp(n);
        bus.hard_sync_en = 1;
        repeat (5) step();
        bus.rx = 0;
        step();
        bus.rx = 1;
        bus.hard_sync_en = 0;
        chk("t2_seg_after_sync", int'(bus.seg), 1);
        s = cyc;
        wait_sp(c);
        chk("t2_sync_to_sample", c - s, 20);

        // resync in TSEG1 at k=2 with sjw=1 lengthens only that bit by 1 tq
        repeat (20) step();
        bus.rx = 0;
        step();
        bus.rx = 1;
        wait_sp(a);
        chk("t3_long_bit", a - c, 36);
        wait_sp(b);
        chk("t3_next_bit", b - a, 32);

        // tseg2=4, sjw=2: truncation at rem=2 and phase-2 shortening at rem=4
        bus.en = 0;
        step();
        bus.ntseg2 = 7'd4;
        bus.nsjw = 7'd2;
        bus.en = 1;
        wait_sp(a);
        wait_sp(n);
        chk("t4_nominal_bit", n - a, 40);
        repeat (11) step();
        bus.rx = 0;
        step();
        bus.rx = 1;
        wait_sp(a);
        chk("t4_trunc_rem2", a - n, 32);
        bus.rx = 0;
        step();
        bus.rx = 1;
        wait_sp(b);
        chk("t4_shrink_rem4", b - a, 32);
        wait_sp(c);
        chk("t4_after_shrink", c - b, 40);

        // data-phase set switches at the sample point
        bus.fd_mode = 1;
        wait_sp(n);
        chk("t5_txreq_at_sample", int'(bus.tx_req), 1);
        step();
        chk("t5_sync_next", int'(bus.seg), 0);
        wait_sp(a);
        chk("t5_fd_bit", a - n, 5);
        wait_sp(b);
        chk("t5_fd_bit2", b - a, 5);
        bus.fd_mode = 0;
        wait_sp(d);

        // own dominant bit with recessive bus flags bit_err; reset mid-TSEG1
        bus.tx_bit = 0;
        wait_sp(d);
        chk("t6_bit_err", int'(bus.bit_err), 1);
        chk("t6_rx_bit", int'(bus.rx_bit), 1);
        for (int i = 0; i < 400 && bus.seg != 2'd1; i++) step();
        repeat (2) step();
        chk("t6_pre_rst_tx", int'(bus.tx), 0);
        rst = 1;
        step();
        rst = 0;
        chk("t6_rst_tx", int'(bus.tx), 1);
        chk("t6_rst_seg", int'(bus.seg), 0);

        for (int r = 0; r < 12; r++) begin
            bus.en = 0;
            step();
            bus.nbrp = BRP_W'($urandom_range(0, 3));
            bus.ntseg1 = TSEG1_W'($urandom_range(2, 6));
            bus.ntseg2 = TSEG2_W'($urandom_range(1, 4));
            bus.nsjw = SJW_W'($urandom_range(1, int'(bus.ntseg2)));
            bus.dbrp = BRP_W'($urandom_range(0, 2));
            bus.dtseg1 = TSEG1_W'($urandom_range(2, 5));
            bus.dtseg2 = TSEG2_W'($urandom_range(1, 3));
            bus.dsjw = SJW_W'($urandom_range(1, int'(bus.dtseg2)));
            step();
            bus.en = 1;
            for (int i = 0; i < 600; i++) begin
                step();
                if ($urandom_range(0, 19) == 0) bus.rx = ~bus.rx;
                if ($urandom_range(0, 49) == 0) bus.hard_sync_en = ~bus.hard_sync_en;
                if ($urandom_range(0, 199) == 0) bus.fd_mode = ~bus.fd_mode;
                bus.tx_bit = 1'($urandom_range(0, 1));
                rst = $urandom_range(0, 499) == 0;
            end
            rst = 0;
        end
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
